// File: rtl/tff_counter_bank.sv
// tff_counter_bank: WIDTH-bit bank of T flip-flops with a selectable mode.
//   mode 00 TOGGLE : q <= q ^ t (per-bit toggle requests)
//   mode 01 UP     : modulo (MAX_COUNT+1) up counter, wraps to 0
//   mode 10 DOWN   : modulo (MAX_COUNT+1) down counter, wraps to MAX_COUNT
//   mode 11 HOLD   : q unchanged
// Priority at each rising edge: re > load > mode operation (gated by en).
//
// Ports:
//   clk       system clock, rising-edge active
//   re        synchronous active-high reset (q <= RESET_VAL, wrap <= 0)
//   en        operation enable for TOGGLE/UP/DOWN
//   mode[1:0] operating mode
//   t         per-bit toggle requests (TOGGLE mode only)
//   load      synchronous load strobe, load_val stored unclamped
//   load_val  value for load
//   q         registered bank state
//   tc        terminal count, combinational from q and mode (ignores en)
//   wrap      registered one-cycle pulse following a counter wrap
//
// Optional build macro TFF_SYNC_IN_EN: t, en, mode, load (and load_val with
// it) pass through a two-flop synchroniser, giving 3-clock input-to-q
// latency. Undefined: inputs are used directly, 1-clock latency.
module tff_counter_bank #(
   parameter int unsigned     WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             re,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;

   logic             en_i;
   logic [1:0]       mode_i;
   logic [WIDTH-1:0] t_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;

`ifdef TFF_SYNC_IN_EN
   logic             en_s1, en_s2;
   logic [1:0]       mode_s1, mode_s2;
   logic [WIDTH-1:0] t_s1, t_s2;
   logic             load_s1, load_s2;
   logic [WIDTH-1:0] load_val_s1, load_val_s2;

   // Clearing the stages on reset makes the first two cycles after release
   // behave as en=0, load=0.
   always_ff @(posedge clk) begin
      if (re) begin
         en_s1       <= 1'b0;
         en_s2       <= 1'b0;
         mode_s1     <= '0;
         mode_s2     <= '0;
         t_s1        <= '0;
         t_s2        <= '0;
         load_s1     <= 1'b0;
         load_s2     <= 1'b0;
         load_val_s1 <= '0;
         load_val_s2 <= '0;
      end else begin
         en_s1       <= en;
         en_s2       <= en_s1;
         mode_s1     <= mode;
         mode_s2     <= mode_s1;
         t_s1        <= t;
         t_s2        <= t_s1;
         load_s1     <= load;
         load_s2     <= load_s1;
         load_val_s1 <= load_val;
         load_val_s2 <= load_val_s1;
      end
   end

   assign en_i       = en_s2;
   assign mode_i     = mode_s2;
   assign t_i        = t_s2;
   assign load_i     = load_s2;
   assign load_val_i = load_val_s2;
`else
   assign en_i       = en;
   assign mode_i     = mode;
   assign t_i        = t;
   assign load_i     = load;
   assign load_val_i = load_val;
`endif

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;

   // Overrange values (q > MAX_COUNT, only reachable via load) wrap to 0
   // in UP and simply decrement in DOWN.
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      if (load_i) begin
         q_nxt = load_val_i;
      end else if (en_i) begin
         case (mode_i)
            MODE_TOGGLE: q_nxt = q ^ t_i;
            MODE_UP: begin
               if (q >= MAX_COUNT) begin
                  q_nxt    = '0;
                  wrap_nxt = 1'b1;
               end else begin
                  q_nxt = q + WIDTH'(1);
               end
            end
            MODE_DOWN: begin
               if (q == '0) begin
                  q_nxt    = MAX_COUNT;
                  wrap_nxt = 1'b1;
               end else begin
                  q_nxt = q - WIDTH'(1);
               end
            end
            default: q_nxt = q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         q    <= RESET_VAL;
         wrap <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
      end
   end

   assign tc = ((mode == MODE_UP) && (q >= MAX_COUNT)) ||
               ((mode == MODE_DOWN) && (q == '0));

endmodule
